// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter: round-robin, one burst in flight,
// beat-count checking and a watchdog that aborts a hung slave.
module axi_rd_arbiter #(
    parameter logic [3:0]  ID_M0   = 4'd0,
    parameter logic [3:0]  ID_M1   = 4'd1,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [63:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [63:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [3:0]  s_arid,
    output logic [1:0]  s_arburst,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [3:0]  s_rid,
    input  logic [63:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [1:0]  grant,
    output logic        err
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ADDR  = 2'd1;
    localparam logic [1:0]  ST_DATA  = 2'd2;
    localparam logic [1:0]  ST_ABORT = 2'd3;
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wd_q, wd_d;

    logic        win_m1, own_rready, beat, cnt_at_len, rid_bad, wd_expire;
    logic        own_rvalid, own_rlast;
    logic [63:0] own_rdata;
    logic [1:0]  own_rresp;

    // Round-robin: M1 wins a tie only when M0 owned the previous burst.
    always_comb begin
        win_m1     = m1_arvalid && (!m0_arvalid || !last_q);
        m0_arready = (state_q == ST_IDLE) && !areset && m0_arvalid && !win_m1;
        m1_arready = (state_q == ST_IDLE) && !areset && win_m1;
        own_rready = owner_q ? m1_rready : m0_rready;
        s_rready   = (state_q == ST_DATA) && own_rready;
        beat       = s_rvalid && s_rready;
        cnt_at_len = (cnt_q == len_q);
        rid_bad    = (s_rid != id_q);
        wd_expire  = (wd_q >= WD_LAST);
    end

    always_comb begin
        own_rvalid = 1'b0;
        own_rdata  = '0;
        own_rresp  = '0;
        own_rlast  = 1'b0;
        if (state_q == ST_DATA) begin
            own_rvalid = s_rvalid;
            own_rdata  = s_rdata;
            own_rresp  = rid_bad ? 2'b10 : s_rresp;
            own_rlast  = s_rlast || cnt_at_len;
        end else if (state_q == ST_ABORT) begin
            own_rvalid = 1'b1;
            own_rresp  = 2'b10;
            own_rlast  = 1'b1;
        end
        m0_rvalid = own_rvalid && !owner_q;
        m0_rdata  = owner_q ? 64'd0 : own_rdata;
        m0_rresp  = owner_q ? 2'b00 : own_rresp;
        m0_rlast  = own_rlast && !owner_q;
        m1_rvalid = own_rvalid && owner_q;
        m1_rdata  = owner_q ? own_rdata : 64'd0;
        m1_rresp  = owner_q ? own_rresp : 2'b00;
        m1_rlast  = own_rlast && owner_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        err_d   = err_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_arready || m1_arready) begin
                    owner_d = m1_arready;
                    addr_d  = m1_arready ? m1_araddr : m0_araddr;
                    len_d   = m1_arready ? m1_arlen  : m0_arlen;
                    size_d  = m1_arready ? m1_arsize : m0_arsize;
                    id_d    = m1_arready ? ID_M1 : ID_M0;
                    grant_d = m1_arready ? 2'b10 : 2'b01;
                    wd_d    = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_arready) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    wd_d    = '0;
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    wd_d  = '0;
                    cnt_d = cnt_q + 8'd1;
                    // Wrong ID, early rlast and missing rlast are all protocol errors.
                    if (rid_bad || (s_rlast != cnt_at_len))
                        err_d = 1'b1;
                    if (s_rlast || cnt_at_len) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                if (own_rready) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    assign s_arvalid = (state_q == ST_ADDR);
    assign s_araddr  = addr_q;
    assign s_arlen   = len_q;
    assign s_arsize  = size_q;
    assign s_arid    = id_q;
    assign s_arburst = 2'b01;
    assign grant     = grant_q;
    assign err       = err_q;

endmodule
